// File: rtl/uart_tx_feeder.sv
// Host-side feeder for the Uart8 transmitter: queues bytes in a FIFO and launches them one at a
// time, handshaking txStart against txBusy/txDone and enforcing an idle gap between bytes.
module uart_tx_feeder #(
   parameter int DEPTH         = 8,
   parameter int START_TIMEOUT = 4096,
   parameter int GAP_CYCLES    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     wrValid,
   input  logic [7:0]               wrData,
   output logic                     wrReady,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     txEn,
   output logic                     txStart,
   output logic [7:0]               txByte,
   input  logic                     txBusy,
   input  logic                     txDone,
   output logic                     sent,
   output logic                     timeoutErr
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int TIMER_W = $clog2(START_TIMEOUT) + 1;
   localparam int GAP_W   = $clog2(GAP_CYCLES + 2);

   localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } stateType;

   stateType state, stateNext;

   logic [7:0]         mem [DEPTH];
   logic [PTR_W-1:0]   rdPtr, wrPtr;
   logic [CNT_W-1:0]   count;
   logic [TIMER_W-1:0] timer, timerNext;
   logic [GAP_W-1:0]   gapCnt, gapCntNext;
   logic [7:0]         txByteNext;
   logic               txStartNext, sentNext, timeoutErrNext;
   logic               doWrite, doPop;

   assign wrReady = (count != FULL_COUNT);
   assign level   = count;
   assign txEn    = en & ~reset;
   assign doWrite = wrValid & wrReady;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Dropping en abandons the byte in flight wherever the FSM is; the FIFO is left untouched.
   always_comb begin
      stateNext      = state;
      timerNext      = timer;
      gapCntNext     = gapCnt;
      txStartNext    = txStart;
      txByteNext     = txByte;
      sentNext       = 1'b0;
      timeoutErrNext = 1'b0;
      doPop          = 1'b0;
      if (!en) begin
         stateNext   = IDLE;
         txStartNext = 1'b0;
         timerNext   = '0;
         gapCntNext  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) begin
                  doPop       = 1'b1;
                  txByteNext  = mem[rdPtr];
                  txStartNext = 1'b1;
                  timerNext   = '0;
                  stateNext   = START;
               end
            end
            START: begin
               // A txDone here means txBusy was missed; the byte still completed.
               if (txDone) begin
                  txStartNext = 1'b0;
                  sentNext    = 1'b1;
                  gapCntNext  = '0;
                  stateNext   = GAP;
               end else if (txBusy) begin
                  txStartNext = 1'b0;
                  stateNext   = BUSY;
               end else if (timer == TIMER_LAST) begin
                  txStartNext    = 1'b0;
                  timeoutErrNext = 1'b1;
                  gapCntNext     = '0;
                  stateNext      = GAP;
               end else begin
                  timerNext = timer + 1'b1;
               end
            end
            BUSY: begin
               if (txDone || !txBusy) begin
                  sentNext   = 1'b1;
                  gapCntNext = '0;
                  stateNext  = GAP;
               end
            end
            GAP: begin
               if (GAP_CYCLES == 0 || gapCnt == GAP_LAST) stateNext = IDLE;
               else                                       gapCntNext = gapCnt + 1'b1;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         rdPtr      <= '0;
         wrPtr      <= '0;
         timer      <= '0;
         gapCnt     <= '0;
         txStart    <= 1'b0;
         txByte     <= 8'h00;
         sent       <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         timer      <= timerNext;
         gapCnt     <= gapCntNext;
         txStart    <= txStartNext;
         txByte     <= txByteNext;
         sent       <= sentNext;
         timeoutErr <= timeoutErrNext;
         if (doWrite) wrPtr <= wrPtr + 1'b1;
         if (doPop)   rdPtr <= rdPtr + 1'b1;
         case ({doWrite, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is not cleared; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (doWrite) mem[wrPtr] <= wrData;
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural Uart8 responder, table-driven single-byte transfers,
// hand-written corner sequences and a randomized run against a queue-based reference model.
module tb_uart_tx_feeder;

   localparam int DEPTH    = 8;
   localparam int TOUT     = 16;
   localparam int GAP      = 4;
   localparam int BUSY_LEN = 6;

   logic                   clk = 1'b0;
   logic                   reset, en, wrValid;
   logic [7:0]             wrData;
   logic                   wrReady, txEn, txStart, sent, timeoutErr;
   logic [$clog2(DEPTH):0] level;
   logic [7:0]             txByte;
   logic                   txBusy, txDone;

   always #5 clk = ~clk;

   uart_tx_feeder #(.DEPTH(DEPTH), .START_TIMEOUT(TOUT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .en(en), .wrValid(wrValid), .wrData(wrData),
      .wrReady(wrReady), .level(level), .txEn(txEn), .txStart(txStart), .txByte(txByte),
      .txBusy(txBusy), .txDone(txDone), .sent(sent), .timeoutErr(timeoutErr)
   );

   int nCmp = 0;
   int nFail = 0;
   int respMode = 0;            // 0 normal, 1 never busy, 2 txDone without txBusy
   logic [7:0] rxQ[$];
   logic [7:0] expQ[$];

   int   cyc = 0, evtCyc = 0, sentCnt = 0, toCnt = 0;
   bit   evtValid = 0, exactGap = 0;
   logic prevStart = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Uart8 stand-in: raises txBusy two cycles after seeing txStart, completes BUSY_LEN later.
   initial begin : responder
      int ucnt;
      logic active;
      logic [7:0] ub;
      txBusy = 1'b0; txDone = 1'b0; ucnt = 0; active = 1'b0; ub = 8'h00;
      forever begin
         @(posedge clk); #2;
         txDone = 1'b0;
         if (reset || !en) begin
            txBusy = 1'b0; active = 1'b0; ucnt = 0;
         end else if (active) begin
            ucnt++;
            if (ucnt >= BUSY_LEN) begin
               txBusy = 1'b0; txDone = 1'b1; active = 1'b0; ucnt = 0;
               rxQ.push_back(ub);
            end
         end else if (txStart && respMode != 1) begin
            ucnt++;
            if (ucnt == 2) begin
               ucnt = 0;
               if (respMode == 0) begin
                  active = 1'b1; txBusy = 1'b1; ub = txByte;
               end else begin
                  txDone = 1'b1; rxQ.push_back(txByte);
               end
            end
         end else begin
            ucnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      cyc++;
      check("sentTimeoutExclusive", {31'd0, sent & timeoutErr}, 32'd0);
      if (txStart && !prevStart && evtValid) begin
         if (exactGap) check("launchGap", cyc - evtCyc, GAP + 1);
         else          check("launchGapMin", {31'd0, (cyc - evtCyc) >= GAP + 1}, 32'd1);
      end
      if (txStart && !prevStart) evtValid = 0;
      if (sent || timeoutErr) begin evtValid = 1; evtCyc = cyc; end
      if (reset || !en) evtValid = 0;
      sentCnt += int'(sent);
      toCnt   += int'(timeoutErr);
      prevStart = txStart;
   endtask

   task automatic wr(input logic [7:0] d);
      wrValid = 1'b1; wrData = d;
      tick();
      wrValid = 1'b0;
   endtask

   task automatic collect(input int n, input int bound);
      int k = 0;
      while (rxQ.size() < n && k < bound) begin tick(); k++; end
      check("collectCount", rxQ.size(), n);
   endtask

   typedef struct {
      logic [7:0] data;
      int         mode;
      int         expHigh;
      int         expSent;
      int         expTo;
   } vecT;

   vecT vecs[6];

   initial begin : main
      int hi, k, starts, mlevel;
      logic [7:0] capByte;
      logic acc, ps;

      vecs[0] = '{8'b10001010, 0, 2,    1, 0};
      vecs[1] = '{8'h00,       0, 2,    1, 0};
      vecs[2] = '{8'hFF,       0, 2,    1, 0};
      vecs[3] = '{8'h5A,       1, TOUT, 0, 1};
      vecs[4] = '{8'hA5,       2, 2,    1, 0};
      vecs[5] = '{8'h3C,       0, 2,    1, 0};

      reset = 1'b1; en = 1'b1; wrValid = 1'b0; wrData = 8'h00;
      repeat (3) tick();
      check("rstTxEn", txEn, 0);
      check("rstLevel", level, 0);
      check("rstWrReady", wrReady, 1);
      check("rstTxStart", txStart, 0);
      check("rstTxByte", txByte, 8'h00);
      check("rstSent", sent, 0);
      check("rstTimeoutErr", timeoutErr, 0);
      reset = 1'b0;
      tick();
      check("txEnAfterReset", txEn, 1);

      // Single-byte transfers from the table
      for (int i = 0; i < 6; i++) begin
         respMode = vecs[i].mode;
         rxQ.delete(); sentCnt = 0; toCnt = 0; hi = 0; capByte = 8'hXX;
         wr(vecs[i].data);
         check("levelAfterWrite", level, 1);
         check("noSameCycleLaunch", txStart, 0);
         repeat (40) begin
            if (txStart) begin
               if (hi == 0) capByte = txByte;
               hi++;
            end
            tick();
         end
         check("startHighCycles", hi, vecs[i].expHigh);
         check("txByteValue", capByte, vecs[i].data);
         check("sentPulses", sentCnt, vecs[i].expSent);
         check("timeoutPulses", toCnt, vecs[i].expTo);
         check("levelDrained", level, 0);
         check("rxCount", rxQ.size(), vecs[i].expSent);
         if (rxQ.size() > 0) check("rxByte", rxQ[0], vecs[i].data);
      end

      // Fill to DEPTH with en low, overflow write ignored, then drain in order with exact gaps
      respMode = 0; en = 1'b0; tick();
      rxQ.delete(); sentCnt = 0;
      for (int i = 0; i < DEPTH; i++) wr(8'(i));
      check("fullWrReady", wrReady, 0);
      check("fullLevel", level, DEPTH);
      wr(8'h99);
      check("overflowLevel", level, DEPTH);
      check("overflowWrReady", wrReady, 0);
      exactGap = 1; en = 1'b1;
      collect(DEPTH, 1000);
      for (int i = 0; i < rxQ.size(); i++) check("fullOrder", rxQ[i], i);
      repeat (GAP + 4) tick();
      exactGap = 0;
      check("fullSentCount", sentCnt, DEPTH);
      check("fullLevelEnd", level, 0);

      // DEPTH-1 queued, then a write and a pop land on the same edge
      en = 1'b0; tick();
      rxQ.delete();
      for (int i = 0; i < DEPTH - 1; i++) wr(8'h10 + 8'(i));
      check("preSimulLevel", level, DEPTH - 1);
      exactGap = 1; en = 1'b1; wrValid = 1'b1; wrData = 8'h10 + 8'(DEPTH - 1);
      tick();
      wrValid = 1'b0;
      check("simulLevel", level, DEPTH - 1);
      check("simulLaunch", txStart, 1);
      collect(DEPTH, 1000);
      for (int i = 0; i < rxQ.size(); i++) check("simulOrder", rxQ[i], 8'h10 + i);
      repeat (GAP + 4) tick();
      exactGap = 0;

      // Timeout on the first byte, second byte launches after the gap
      respMode = 1; rxQ.delete(); toCnt = 0;
      wr(8'h61); wr(8'h62);
      k = 0;
      while (!timeoutErr && k < 100) begin tick(); k++; end
      check("timeoutSeen", timeoutErr, 1);
      respMode = 0; exactGap = 1;
      collect(1, 200);
      if (rxQ.size() > 0) check("afterTimeoutByte", rxQ[0], 8'h62);
      repeat (GAP + 4) tick();
      exactGap = 0;
      check("afterTimeoutCount", toCnt, 1);

      // Drop en while the first byte is busy
      rxQ.delete(); sentCnt = 0;
      wr(8'h3C); wr(8'hC3);
      k = 0;
      while (!txBusy && k < 50) begin tick(); k++; end
      check("enDropBusySeen", txBusy, 1);
      check("enDropLevel", level, 1);
      en = 1'b0;
      tick();
      check("enDropTxStart", txStart, 0);
      check("enDropTxEn", txEn, 0);
      repeat (5) tick();
      check("enDropNoSent", sentCnt, 0);
      check("enDropKeepsFifo", level, 1);
      en = 1'b1;
      collect(1, 200);
      if (rxQ.size() > 0) check("enDropSecondByte", rxQ[0], 8'hC3);
      repeat (GAP + 4) tick();
      check("enDropSentOnce", sentCnt, 1);

      // Reset with three bytes queued and one in flight
      en = 1'b0; tick();
      rxQ.delete();
      for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
      en = 1'b1;
      k = 0;
      while (!txBusy && k < 50) begin tick(); k++; end
      check("rstMidBusySeen", txBusy, 1);
      check("rstMidLevelBefore", level, 3);
      reset = 1'b1;
      tick();
      check("rstMidLevel", level, 0);
      check("rstMidWrReady", wrReady, 1);
      check("rstMidTxStart", txStart, 0);
      check("rstMidTxByte", txByte, 8'h00);
      reset = 1'b0; sentCnt = 0; starts = 0;
      repeat (50) begin tick(); if (txStart) starts++; end
      check("rstMidNoLaunch", starts, 0);
      check("rstMidNoRx", rxQ.size(), 0);
      check("rstMidNoSent", sentCnt, 0);

      // Randomized traffic against a queue model of the FIFO
      respMode = 0; rxQ.delete(); expQ.delete(); mlevel = 0;
      for (int c = 0; c < 600; c++) begin
         wrValid = 1'($urandom_range(0, 1));
         wrData  = 8'($urandom);
         acc = wrValid && (mlevel != DEPTH);
         if (acc) expQ.push_back(wrData);
         ps = txStart;
         tick();
         if (acc) mlevel++;
         if (txStart && !ps) mlevel--;
         check("randLevel", level, mlevel);
         check("randWrReady", wrReady, {31'd0, mlevel != DEPTH});
      end
      wrValid = 1'b0;
      collect(expQ.size(), 3000);
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) check("randData", rxQ[i], expQ[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
